// File: rtl/prm_sweep_pkg.sv
// Shared types and constants for the PRM edge sweep controller.
// chk_vec packs the 15 joint/obstacle predicates A..O, LSB first.
package prm_sweep_pkg;

  localparam int CHK_W = 15;
  localparam int BIT_A = 0;
  localparam int BIT_O = 14;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ZERO,
    DRAIN
  } state_t;

endpackage

// File: rtl/prm_result_packer.sv
// Folds per-sample collision masks into per-edge bits and packs
// them into result words on a valid/ready stream.
module prm_result_packer
  import prm_sweep_pkg::*;
#(
  parameter int RW = 32
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          clr,
  input  logic          flush,
  input  logic          ret,
  input  logic          eos,
  input  logic          lst,
  input  logic          mask,
  input  logic          res_ready,
  output logic          res_valid,
  output logic [RW-1:0] res_data,
  output logic          res_last,
  output logic [15:0]   blocked_cnt
);

  localparam int PW = $clog2(RW);

  logic          acc;
  logic [RW-1:0] pack;
  logic [PW-1:0] pos;
  logic          blk;
  logic          emit;
  logic [RW-1:0] pack_n;

  always_comb begin
    blk       = acc | mask;
    pack_n    = pack;
    pack_n[pos] = blk;
    emit      = ret & eos & (lst | (pos == PW'(RW - 1)));
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      acc         <= 1'b0;
      pack        <= '0;
      pos         <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_last    <= 1'b0;
      blocked_cnt <= '0;
    end else if (clr | flush) begin
      acc       <= 1'b0;
      pack      <= '0;
      pos       <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      if (clr) begin
        blocked_cnt <= '0;
        res_data    <= '0;
      end
    end else begin
      if (res_valid & res_ready) begin
        res_valid <= 1'b0;
        res_last  <= 1'b0;
      end
      if (ret) begin
        if (eos) begin
          acc <= 1'b0;
          pos <= pos + 1'b1;
          if (blk && blocked_cnt != 16'hFFFF)
            blocked_cnt <= blocked_cnt + 16'd1;
          // emit overrides the handshake clear above
          if (emit) begin
            res_data  <= pack_n;
            res_valid <= 1'b1;
            res_last  <= lst;
            pack      <= '0;
            pos       <= '0;
          end else begin
            pack <= pack_n;
          end
        end else begin
          acc <= blk;
        end
      end
    end
  end

endmodule

// File: rtl/prm_edge_sweep_ctrl.sv
// Walks a roadmap edge list through the external obstacle checker,
// reading SPE sample configs per edge from the edge-sample RAM.
module prm_edge_sweep_ctrl
  import prm_sweep_pkg::*;
#(
  parameter int AW  = 12,
  parameter int CW  = CHK_W,
  parameter int SPE = 8,
  parameter int RW  = 32
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [15:0]   edge_cnt,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [CW-1:0] mem_rd_data,
  output logic [CW-1:0] chk_vec,
  input  logic          chk_mask,
  output logic          res_valid,
  output logic [RW-1:0] res_data,
  output logic          res_last,
  input  logic          res_ready,
  output logic [15:0]   blocked_cnt
);

  localparam int SW = (SPE > 1) ? $clog2(SPE) : 1;

  state_t        state, state_n;
  logic [AW-1:0] addr;
  logic [15:0]   cnt;
  logic [15:0]   e_idx;
  logic [SW-1:0] s_idx;
  logic          p1_v, p1_eos, p1_lst;
  logic          p2_v, p2_eos, p2_lst;
  logic          accept, stall, issue;
  logic          last_s, last_e;
  logic          drain_ok, done_n;

  always_comb begin
    accept   = (state == IDLE) & start & ~abort;
    stall    = res_valid & ~res_ready;
    last_s   = (s_idx == SW'(SPE - 1));
    last_e   = (e_idx == cnt - 16'd1);
    issue    = (state == RUN) & ~stall & ~abort;
    drain_ok = res_valid & res_ready & res_last & ~p1_v & ~p2_v;
    state_n  = state;
    done_n   = 1'b0;
    unique case (state)
      IDLE:
        if (accept)
          state_n = (edge_cnt == 16'd0) ? ZERO : RUN;
      RUN:
        if (issue & last_s & last_e)
          state_n = DRAIN;
      ZERO: begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      DRAIN:
        if (drain_ok) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      done_n  = 1'b0;
    end
  end

  assign busy      = (state != IDLE);
  assign mem_rd_en = issue;
  assign mem_addr  = addr;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state   <= IDLE;
      done    <= 1'b0;
      addr    <= '0;
      cnt     <= '0;
      e_idx   <= '0;
      s_idx   <= '0;
      p1_v    <= 1'b0;
      p1_eos  <= 1'b0;
      p1_lst  <= 1'b0;
      p2_v    <= 1'b0;
      p2_eos  <= 1'b0;
      p2_lst  <= 1'b0;
      chk_vec <= '0;
    end else begin
      state <= state_n;
      done  <= done_n;
      if (accept) begin
        addr  <= base_addr;
        cnt   <= edge_cnt;
        e_idx <= '0;
        s_idx <= '0;
      end else if (issue) begin
        addr <= addr + 1'b1;
        if (last_s) begin
          s_idx <= '0;
          e_idx <= e_idx + 16'd1;
        end else begin
          s_idx <= s_idx + 1'b1;
        end
      end
      // tags ride alongside the RAM read so retire knows edge boundaries
      p1_v   <= issue;
      p1_eos <= last_s;
      p1_lst <= last_s & last_e;
      p2_v   <= p1_v & ~abort;
      p2_eos <= p1_eos;
      p2_lst <= p1_lst;
      if (p1_v)
        chk_vec <= mem_rd_data;
    end
  end

  prm_result_packer #(
    .RW(RW)
  ) u_packer (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .clr        (accept),
    .flush      (abort),
    .ret        (p2_v),
    .eos        (p2_eos),
    .lst        (p2_lst),
    .mask       (chk_mask),
    .res_ready  (res_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_last   (res_last),
    .blocked_cnt(blocked_cnt)
  );

endmodule

// File: tb/tb_prm_edge_sweep_ctrl.sv
// Randomized bench for prm_edge_sweep_ctrl against an edge-list model.
// Collision stand-in: sample is blocked when predicate O is set.
module tb_prm_edge_sweep_ctrl;

  localparam int AW  = 12;
  localparam int CW  = 15;
  localparam int SPE = 8;
  localparam int RW  = 32;
  localparam int MS  = 2 ** AW;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   edge_cnt = '0;
  logic          busy, done, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_rd_data = '0;
  logic [CW-1:0] chk_vec;
  logic          chk_mask;
  logic          res_valid, res_last;
  logic          res_ready = 1'b1;
  logic [RW-1:0] res_data;
  logic [15:0]   blocked_cnt;

  logic [CW-1:0] mem [MS];

  int total = 0;
  int bad = 0;

  logic [RW:0]   exp_q[$];
  logic [RW:0]   word_log[$];
  logic [AW-1:0] addr_log[$];
  logic [AW-1:0] m_base = '0;
  int rd_idx = 0;
  int m_total = 0;
  int done_cnt = 0;
  int words_seen = 0;
  int exp_blk = 0;
  int ready_pct = 100;
  int hold = 0;
  bit stall_arm = 1'b0;

  always #5 CLK = ~CLK;

  prm_edge_sweep_ctrl #(
    .AW(AW), .CW(CW), .SPE(SPE), .RW(RW)
  ) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .start      (start),
    .base_addr  (base_addr),
    .edge_cnt   (edge_cnt),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .chk_vec    (chk_vec),
    .chk_mask   (chk_mask),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_last   (res_last),
    .res_ready  (res_ready),
    .blocked_cnt(blocked_cnt)
  );

  assign chk_mask = chk_vec[14];

  always @(posedge CLK)
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW:0] wl(input int i);
    return (i < word_log.size()) ? word_log[i] : '1;
  endfunction

  function automatic logic [AW-1:0] al(input int i);
    return (i < addr_log.size()) ? addr_log[i] : 'x;
  endfunction

  initial forever begin
    @(posedge CLK);
    #1;
    if (stall_arm && res_valid) begin
      hold = 20;
      stall_arm = 1'b0;
    end
    if (hold > 0) begin
      res_ready = 1'b0;
      hold--;
    end else begin
      res_ready = ($urandom_range(99) < ready_pct);
    end
  end

  always @(negedge CLK) begin
    if (RST_n) begin
      if (mem_rd_en) begin
        check("rd_addr", mem_addr, (m_base + rd_idx) % MS);
        check("rd_range", rd_idx < m_total, 1);
        check("rd_stall", res_valid & ~res_ready, 0);
        addr_log.push_back(mem_addr);
        rd_idx++;
      end
      if (res_valid) begin
        check("word_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("res_data", res_data, exp_q[0][RW-1:0]);
          check("res_last", res_last, exp_q[0][RW]);
          if (res_ready) begin
            word_log.push_back({res_last, res_data});
            void'(exp_q.pop_front());
            words_seen++;
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic fill_mem(input int pct);
    for (int a = 0; a < MS; a++)
      mem[a] = {($urandom_range(99) < pct), 14'($urandom)};
  endtask

  task automatic build_model(input logic [AW-1:0] b, input int n);
    int nw;
    logic [RW-1:0] w;
    bit blk;
    exp_q.delete();
    exp_blk = 0;
    nw = (n + RW - 1) / RW;
    for (int wi = 0; wi < nw; wi++) begin
      w = '0;
      for (int k = 0; k < RW; k++) begin
        if (wi * RW + k < n) begin
          blk = 1'b0;
          for (int s = 0; s < SPE; s++)
            blk |= mem[(b + (wi * RW + k) * SPE + s) % MS][14];
          w[k] = blk;
          exp_blk += int'(blk);
        end
      end
      exp_q.push_back({(wi == nw - 1), w});
    end
  endtask

  task automatic arm(input logic [AW-1:0] b, input int n);
    m_base = b;
    m_total = n * SPE;
    rd_idx = 0;
    done_cnt = 0;
    words_seen = 0;
    word_log.delete();
    addr_log.delete();
    build_model(b, n);
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input int n);
    @(posedge CLK);
    #1;
    base_addr = b;
    edge_cnt = 16'(n);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (done_cnt == 0 && cyc < 5000) begin
      @(negedge CLK);
      cyc++;
    end
    check("done_seen", done_cnt > 0, 1);
    if (done_cnt == 0) begin
      @(posedge CLK);
      #1 abort = 1'b1;
      @(posedge CLK);
      #1 abort = 1'b0;
      exp_q.delete();
    end
    repeat (5) @(negedge CLK);
  endtask

  task automatic sweep(input logic [AW-1:0] b, input int n, input int pct,
                       input bit stl, input bit spur);
    if (pct >= 0) fill_mem(pct);
    arm(b, n);
    stall_arm = stl;
    pulse_start(b, n);
    if (spur) begin
      repeat (3) @(posedge CLK);
      pulse_start(b + 12'd100, n + 5);
    end
    wait_done();
    check("done_once", done_cnt, 1);
    check("reads", rd_idx, m_total);
    check("words", words_seen, (n + RW - 1) / RW);
    check("blocked", blocked_cnt, exp_blk);
    check("busy_idle", busy, 0);
    check("valid_idle", res_valid, 0);
  endtask

  initial begin
    logic [AW-1:0] b;
    int n_rd;

    #2 RST_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_blk", blocked_cnt, 0);
    check("rst_chk", chk_vec, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;

    // all clear, three edges
    fill_mem(0);
    sweep(12'($urandom), 3, -1, 1'b0, 1'b0);
    check("t1_word", wl(0), {1'b1, 32'h0});

    // two isolated collisions
    for (int a = 0; a < MS; a++) mem[a] = 15'($urandom) & 15'h3FFF;
    b = 12'($urandom);
    mem[(b + 5 * SPE + 7) % MS][14] = 1'b1;
    mem[(b + 32 * SPE) % MS][14] = 1'b1;
    sweep(b, 33, -1, 1'b0, 1'b0);
    check("t2_w0", wl(0), {1'b0, 32'h0000_0020});
    check("t2_w1", wl(1), {1'b1, 32'h1});
    check("t2_blk", blocked_cnt, 2);

    // address wrap
    sweep(12'hFF8, 2, 30, 1'b0, 1'b0);
    check("t3_n", addr_log.size(), 16);
    check("t3_a7", al(7), 12'hFFF);
    check("t3_a8", al(8), 12'h000);
    check("t3_a15", al(15), 12'h007);

    // consumer stall on first word
    sweep(12'($urandom), 64, 20, 1'b1, 1'b0);

    // abort with reads in flight
    fill_mem(50);
    b = 12'($urandom);
    arm(b, 40);
    pulse_start(b, 40);
    repeat (4) @(posedge CLK);
    #1 abort = 1'b1;
    @(posedge CLK);
    #1 abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_valid", res_valid, 0);
    exp_q.delete();
    n_rd = rd_idx;
    repeat (10) @(negedge CLK);
    check("ab_done", done_cnt, 0);
    check("ab_reads", rd_idx, n_rd);
    @(posedge CLK);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 0);
    sweep(12'($urandom), 40, -1, 1'b0, 1'b0);

    // empty list, then start while busy
    sweep(12'($urandom), 0, -1, 1'b0, 1'b0);
    sweep(12'($urandom), 50, 40, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      ready_pct = $urandom_range(100, 50);
      sweep(12'($urandom), $urandom_range(90, 1), $urandom_range(30),
            1'($urandom), 1'b0);
    end
    ready_pct = 100;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
